// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and line/parity levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic PAR_EVEN    = 1'b0;
    localparam logic PAR_ODD     = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit timing for the UART transmitter: a per-bit cycle counter and a data-bit index.
module uart_tx_bit_timer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [4:0]       prescale_i,
    input  logic             bit_adv_i,
    output logic             bit_done_o,
    output logic [CNT_W-1:0] bit_cnt_o
);

    logic [4:0]       edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    // prescale_i is already clamped to >= 1 by the caller, so P-1 never underflows
    assign bit_done_o = en_i && (edge_cnt_q == 5'(prescale_i - 5'd1));
    assign bit_cnt_o  = bit_cnt_q;

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (!en_i) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else begin
            edge_cnt_d = bit_done_o ? 5'd0 : 5'(edge_cnt_q + 5'd1);
            if (bit_done_o && bit_adv_i) begin
                bit_cnt_d = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) ? '0
                                                                   : CNT_W'(bit_cnt_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// UART transmitter: latches one word plus line config, then shifts out
// start / data (LSB first) / optional parity / stop with registered outputs.
module uart_tx_frame_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [4:0]            prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic                  bit_done;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      nxt_idx;

    uart_tx_bit_timer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .en_i       (state_q != IDLE),
        .prescale_i (prescale_q),
        .bit_adv_i  (state_q == DATA),
        .bit_done_o (bit_done),
        .bit_cnt_o  (bit_cnt)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        parity_d   = parity_q;
        nxt_idx    = bit_cnt;
        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    state_d    = START;
                    data_d     = p_data;
                    prescale_d = (prescale == 5'd0) ? 5'd1 : prescale;
                    par_en_d   = par_en;
                    parity_d   = (^p_data) ^ (par_typ == PAR_ODD);
                end
            end
            START:  if (bit_done) state_d = DATA;
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) state_d = par_en_q ? PARITY : STOP;
                    else                                   nxt_idx = CNT_W'(bit_cnt + 1'b1);
                end
            end
            PARITY: if (bit_done) state_d = STOP;
            STOP:   if (bit_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The line level is computed for the state being entered so tx_out can stay a flop.
        case (state_d)
            START:   tx_d = START_LEVEL;
            DATA:    tx_d = data_q[nxt_idx];
            PARITY:  tx_d = parity_q;
            default: tx_d = IDLE_LEVEL;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= IDLE_LEVEL;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule

// File: doc/uart_tx_frame_serializer.md
Name: uart_tx_frame_serializer

Overview:
Transmit side of the UART link; counterpart of the receive-side oversampling edge/bit counters. It accepts one parallel data word with a single-cycle valid strobe and drives one serial line. Each frame is start bit, DATA_WIDTH data bits LSB first, optional parity bit, then stop bit. Each bit is held for a programmable number of clock cycles (prescale), so both link ends share one prescale configuration.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (supported 5..8)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
prescale  input  5  clock cycles per bit; 0 treated as 1; sampled only when a word is accepted
par_en  input  1  1 = parity bit inserted; sampled at acceptance
par_typ  input  1  0 = even parity, 1 = odd parity; sampled at acceptance
p_data  input  DATA_WIDTH  parallel word to send
data_valid  input  1  single-cycle strobe; p_data is valid this cycle
tx_out  output  1  serial line; idle level 1
busy  output  1  high while a frame is in progress

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, tx_out=1, busy=0, counters 0, latched data/config 0. Reset mid-frame aborts immediately; the line returns to 1 on the next edge and no partial bits resume.
- Acceptance: only in IDLE. data_valid=1 at edge N latches p_data, prescale (0 becomes 1), par_en, par_typ, and parity bit = XOR(p_data) XOR par_typ. data_valid while busy=1 is ignored and has no effect.
- Latency: from edge N+1, tx_out=0 (start bit) and busy=1.
- FSM: IDLE -> START -> DATA -> PARITY (only if par_en latched) -> STOP -> IDLE.
- Bit timing: edge_cnt counts 0..P-1, where P is the latched prescale. On edge_cnt=P-1 it wraps to 0 and the bit ends. Each state holds tx_out for exactly P cycles.
- DATA state: bit_cnt 0..DATA_WIDTH-1; tx_out = data[bit_cnt]. Leave DATA when bit_cnt=DATA_WIDTH-1 and the bit ends. bit_cnt returns to 0.
- PARITY state: tx_out = latched parity bit. STOP state: tx_out=1.
- Frame length: P*(2+DATA_WIDTH+par_en) cycles of busy=1.
- End of frame: busy falls at the edge ending the stop bit, so there is a minimum of one IDLE cycle between frames. data_valid in that IDLE cycle is accepted.
- Input stability: changes to prescale, par_en or par_typ mid-frame do not affect the current frame.
- Outputs: tx_out and busy are registered, with no combinational path from inputs.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - parity constants PAR_EVEN=0, PAR_ODD=1
  - IDLE_LEVEL=1'b1, START_LEVEL=1'b0
- Sub-module uart_tx_bit_timer:
  - holds edge_cnt and bit_cnt
  - inputs: enable, latched prescale, bit-advance enable
  - outputs: bit_done pulse and bit_cnt
  - top level holds the FSM, data/parity registers and output mux.

Test Plan:
- Reset: rst=1 for 3 cycles with data_valid=1 -> tx_out=1, busy=0 throughout; nothing transmitted after release.
- Basic frame: prescale=8, par_en=0, p_data=0xA5, one-cycle data_valid -> tx_out holds each level 8 cycles: 0,1,0,1,0,0,1,0,1,1. busy high exactly 80 cycles, rising one cycle after the strobe.
- Parity: prescale=4, par_en=1, p_data=0x07. par_typ=0 -> parity bit 1; par_typ=1 -> parity bit 0. Frame is 44 busy cycles.
- Busy rejection: second data_valid (0x3C) mid-frame -> frame still carries the first word; no second frame follows. Strobe in the first IDLE cycle after busy falls -> 0x3C sent, starting the next cycle.
- Prescale edge cases and config freeze: prescale=0 -> 1-cycle bits, busy 10 cycles. prescale=31 -> busy 310 cycles. Changing prescale/par_en mid-frame leaves timing and parity unchanged.
- Mid-frame reset: rst during DATA bit 3 -> tx_out=1, busy=0 on the next edge. A new strobe one cycle after reset release starts a clean frame.
